// File: rtl/axi_bresp_gen.sv
// AXI write-response generator: queues burst commands, folds the per-beat AHB HRESP
// values of each burst into one BRESP, and presents it on the AXI B channel.
module axi_bresp_gen #(
   parameter int ID_W      = 4,
   parameter int LEN_W     = 8,
   parameter int CMD_DEPTH = 4
) (
   input  logic             rclk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ID_W-1:0]  cmd_id,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             resp_rd_en,
   input  logic [1:0]       resp_data,
   input  logic             resp_empty,
   output logic             bvalid,
   input  logic             bready,
   output logic [ID_W-1:0]  bid,
   output logic [1:0]       bresp,
   output logic             busy
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = $clog2(CMD_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [ID_W-1:0]  q_id  [CMD_DEPTH];
   logic [LEN_W-1:0] q_len [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, q_empty;

   logic [ID_W-1:0]  cur_id;
   logic [LEN_W-1:0] beats_left;
   logic             err;

   assign q_empty   = (count == '0);
   assign cmd_ready = (count != CNT_W'(CMD_DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign busy      = (state != IDLE) | ~q_empty;

   // ---------------- command queue ----------------
   always_ff @(posedge rclk) begin
      if (push) begin
         q_id[wr_ptr]  <= cmd_id;
         q_len[wr_ptr] <= cmd_len;
      end
   end

   always_ff @(posedge rclk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge rclk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      resp_rd_en = 1'b0;
      bvalid     = 1'b0;
      case (state)
         IDLE: begin
            if (!q_empty) begin
               pop       = 1'b1;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            resp_rd_en = ~resp_empty;
            if (!resp_empty && beats_left == '0) state_nxt = RESP;
         end
         RESP: begin
            bvalid = 1'b1;
            // Back-to-back bursts: the next command is popped on the handshake itself.
            if (bready) begin
               if (!q_empty) begin
                  pop       = 1'b1;
                  state_nxt = COLLECT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- burst datapath ----------------
   always_ff @(posedge rclk) begin
      if (reset) begin
         cur_id     <= '0;
         beats_left <= '0;
         err        <= 1'b0;
      end else if (pop) begin
         cur_id     <= q_id[rd_ptr];
         beats_left <= q_len[rd_ptr];
         err        <= 1'b0;
      end else if (resp_rd_en) begin
         err <= err | (resp_data != 2'b00);
         if (beats_left != '0) beats_left <= beats_left - LEN_W'(1);
      end
   end

   assign bid   = bvalid ? cur_id : '0;
   assign bresp = (bvalid && err) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_bresp_gen.sv
// Scoreboard bench for axi_bresp_gen: commands push expected {id, bresp} and their
// beats into model queues; independent processes model the FIFO and check the B channel.
module tb_axi_bresp_gen;

   localparam int ID_W      = 4;
   localparam int LEN_W     = 8;
   localparam int CMD_DEPTH = 4;

   logic             rclk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [ID_W-1:0]  cmd_id = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             resp_rd_en;
   logic [1:0]       resp_data = 2'b00;
   logic             resp_empty = 1'b1;
   logic             bvalid;
   logic             bready = 1'b0;
   logic [ID_W-1:0]  bid;
   logic [1:0]       bresp;
   logic             busy;

   always #5 rclk = ~rclk;

   axi_bresp_gen #(
      .ID_W     (ID_W),
      .LEN_W    (LEN_W),
      .CMD_DEPTH(CMD_DEPTH)
   ) dut (
      .rclk      (rclk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_id    (cmd_id),
      .cmd_len   (cmd_len),
      .resp_rd_en(resp_rd_en),
      .resp_data (resp_data),
      .resp_empty(resp_empty),
      .bvalid    (bvalid),
      .bready    (bready),
      .bid       (bid),
      .bresp     (bresp),
      .busy      (busy)
   );

   typedef struct {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] fifo_q[$];
   int         beats_q[$];
   logic [1:0] forced[$];

   int fifo_mode = 1;     // 0 random gaps, 1 always available, 2 toggling, 3 stalled
   int brdy_mode = 1;     // 0 random, 1 high, 2 low
   bit expect_bv = 1'b0;
   int pending_done = 0;
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Response FIFO model: data is presented only while the model queue holds beats.
   initial begin : fifo_drv
      bit take;
      bit tog;
      tog = 1'b0;
      forever begin
         @(negedge rclk);
         take = resp_rd_en && !resp_empty;
         if (!reset && resp_empty) chk("rd_en_while_empty", resp_rd_en, 0);
         @(posedge rclk);
         #1;
         if (take && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            if (beats_q.size() > 0) begin
               beats_q[0]--;
               if (beats_q[0] == 0) begin
                  void'(beats_q.pop_front());
                  expect_bv = 1'b1;
                  pending_done++;
               end
            end
         end
         tog = ~tog;
         if (fifo_q.size() == 0 || fifo_mode == 3) resp_empty = 1'b1;
         else begin
            case (fifo_mode)
               1:       resp_empty = 1'b0;
               2:       resp_empty = tog;
               default: resp_empty = ($urandom_range(0, 2) == 0);
            endcase
         end
         resp_data = resp_empty ? 2'($urandom_range(0, 3)) : fifo_q[0];
      end
   end

   initial begin : brdy_drv
      forever begin
         @(posedge rclk);
         #1;
         case (brdy_mode)
            1:       bready = 1'b1;
            2:       bready = 1'b0;
            default: bready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // B-channel monitor
   initial begin : mon
      logic            pv, prdy;
      logic [ID_W-1:0] pid;
      logic [1:0]      pr;
      exp_t            e;
      pv = 1'b0; prdy = 1'b0; pid = '0; pr = 2'b00;
      forever begin
         @(negedge rclk);
         if (reset) begin
            pv = 1'b0;
            continue;
         end
         if (expect_bv) begin
            chk("bvalid_latency", bvalid, 1);
            expect_bv = 1'b0;
         end
         if (pv && !prdy) begin
            chk("bvalid_hold", bvalid, 1);
            chk("bid_hold", bid, pid);
            chk("bresp_hold", bresp, pr);
         end
         if (bvalid && bready) begin
            chk("b_after_last_beat", pending_done > 0, 1);
            if (pending_done > 0) pending_done--;
            chk("b_with_expectation", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("bid", bid, e.id);
               chk("bresp", bresp, e.resp);
            end
         end
         pv = bvalid; prdy = bready; pid = bid; pr = bresp;
      end
   end

   task automatic send_cmd(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len, input bit gen);
      int         guard;
      logic [1:0] v;
      bit         any_err;
      guard = 0;
      any_err = 1'b0;
      @(posedge rclk);
      #1;
      cmd_id = id; cmd_len = len; cmd_valid = 1'b1;
      forever begin
         @(negedge rclk);
         if (cmd_ready) break;
         guard++;
         if (guard > 5000) begin
            chk("cmd_accept_timeout", cmd_ready, 1);
            break;
         end
      end
      if (cmd_ready && gen) begin
         for (int unsigned i = 0; i <= 32'(len); i++) begin
            if (forced.size() > 0) v = forced.pop_front();
            else v = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fifo_q.push_back(v);
            if (v != 2'b00) any_err = 1'b1;
         end
         beats_q.push_back(int'(len) + 1);
         exp_q.push_back('{id, any_err ? 2'b10 : 2'b00});
      end
      @(posedge rclk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      forever begin
         @(negedge rclk);
         if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) break;
         guard++;
         if (guard > 5000) begin
            chk("drain_timeout", exp_q.size(), 0);
            break;
         end
      end
   endtask

   initial begin : main
      int guard;
      repeat (3) @(negedge rclk);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bid", bid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rd_en", resp_rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      reset = 1'b0;

      // single-beat OKAY, then a 4-beat burst with one ERROR beat
      forced = '{2'b00};
      send_cmd(4'd3, 8'd0, 1'b1);
      drain();
      forced = '{2'b00, 2'b01, 2'b00, 2'b00};
      send_cmd(4'd5, 8'd3, 1'b1);
      drain();

      // FIFO empty toggling every other cycle
      fifo_mode = 2;
      send_cmd(4'd6, 8'd3, 1'b1);
      send_cmd(4'd7, 8'd3, 1'b1);
      drain();

      // bready held low: response held, next burst starts right after the handshake
      fifo_mode = 1;
      brdy_mode = 2;
      send_cmd(4'd1, 8'd0, 1'b1);
      send_cmd(4'd2, 8'd1, 1'b1);
      repeat (10) @(negedge rclk);
      chk("stall_bvalid", bvalid, 1);
      chk("stall_bid", bid, 1);
      brdy_mode = 1;
      guard = 0;
      while (!(bvalid && bready) && guard < 20) begin
         @(negedge rclk);
         guard++;
      end
      chk("handshake_seen", bvalid && bready, 1);
      @(negedge rclk);
      chk("no_bubble_rd_en", resp_rd_en, 1);
      drain();

      // fill the command queue while the FSM is stalled on an empty FIFO
      fifo_mode = 3;
      for (int unsigned k = 0; k <= CMD_DEPTH; k++)
         send_cmd(ID_W'(8 + k), LEN_W'($urandom_range(0, 3)), 1'b1);
      @(posedge rclk);
      #1;
      cmd_id = 4'hF; cmd_len = 8'd0; cmd_valid = 1'b1;
      repeat (4) begin
         @(negedge rclk);
         chk("full_cmd_ready", cmd_ready, 0);
      end
      @(posedge rclk);
      #1;
      cmd_valid = 1'b0;
      @(negedge rclk);
      chk("full_busy", busy, 1);
      fifo_mode = 0;
      drain();

      // reset in the middle of a burst after 2 of 4 beats
      fifo_mode = 1;
      send_cmd(4'd9, 8'd3, 1'b0);
      @(negedge rclk);
      fifo_q.push_back(2'b00);
      fifo_q.push_back(2'b01);
      beats_q.push_back(4);
      repeat (8) @(negedge rclk);
      chk("midburst_busy", busy, 1);
      chk("midburst_bvalid", bvalid, 0);
      fifo_q.delete();
      beats_q.delete();
      exp_q.delete();
      expect_bv = 1'b0;
      pending_done = 0;
      reset = 1'b1;
      @(negedge rclk);
      chk("mrst_bvalid", bvalid, 0);
      chk("mrst_bid", bid, 0);
      chk("mrst_bresp", bresp, 0);
      chk("mrst_rd_en", resp_rd_en, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_cmd_ready", cmd_ready, 1);
      reset = 1'b0;
      forced = '{2'b00, 2'b00};
      send_cmd(4'd10, 8'd1, 1'b1);
      drain();

      // maximum length: 2^LEN_W beats
      send_cmd(4'd4, 8'd255, 1'b1);
      drain();

      // randomized traffic
      @(negedge rclk);
      fifo_mode = 0;
      brdy_mode = 0;
      repeat (40) begin
         send_cmd(ID_W'($urandom_range(0, 15)), LEN_W'($urandom_range(0, 7)), 1'b1);
         repeat ($urandom_range(0, 3)) @(posedge rclk);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
